vid_line_prefetch_ctrl: RTL

- Sequences frame-buffer reads that feed the DVI transmitter's pixel path, one video line ahead of display.
- On each preload window from the timing generator, it fetches one line into a ping-pong line buffer using burst reads.
- At the start of each active line, it hands the completed bank to the pixel reader and flags late fetches.
- Sits between the HDMI_out timing/encoder chain and the memory read port.

---
 rtl/vid_line_prefetch_ctrl_pkg.sv | 24 ++
 rtl/vid_edge_det.sv | 24 ++
 rtl/vid_line_prefetch_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vid_line_prefetch_ctrl_pkg.sv
// Shared types and width helpers for the video line prefetch controller.
package vid_line_prefetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int v);
    return (v > 1) ? ceil_log2(v) : 1;
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Registered rising-edge detector; the pulse lags the input edge by one clock.
module vid_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;
  logic r_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_q    <= i_d;
      r_rise <= i_d & ~r_q;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/vid_line_prefetch_ctrl.sv
// Fetches one video line ahead of display into a ping-pong buffer using
// burst reads, and hands the finished bank to the pixel reader.
module vid_line_prefetch_ctrl
  import vid_line_prefetch_ctrl_pkg::*;
#(
  parameter int H_RES_PIX   = 640,
  parameter int V_RES_PIX   = 480,
  parameter int BURST_LEN   = 64,
  parameter int ADDR_BITS   = 24,
  parameter int FRAME_BASE  = 0,
  parameter int LINE_STRIDE = 640
) (
  input  logic                                  p_clk_x1,
  input  logic                                  reset,
  input  logic                                  preload_vid_line,
  input  logic                                  active,
  input  logic                                  frame_start,
  output logic                                  mem_req,
  output logic [ADDR_BITS-1:0]                  mem_addr,
  output logic [ceil_log2(BURST_LEN+1)-1:0]     mem_len,
  input  logic                                  mem_ack,
  input  logic                                  mem_rd_valid,
  output logic                                  buf_wr_en,
  output logic                                  buf_wr_bank,
  output logic [ceil_log2(H_RES_PIX)-1:0]       buf_wr_addr,
  output logic                                  rd_bank,
  output logic                                  line_ready,
  output logic                                  underrun,
  output logic                                  busy
);

  localparam int NBURST = H_RES_PIX / BURST_LEN;
  localparam int BCW    = cnt_w(NBURST);
  localparam int BTW    = cnt_w(BURST_LEN);
  localparam int LCW    = cnt_w(V_RES_PIX);
  localparam int PXW    = ceil_log2(H_RES_PIX);
  localparam int LENW   = ceil_log2(BURST_LEN + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_start;
  logic                 w_act_rise;
  logic [BCW-1:0]       r_burst_cnt;
  logic [BTW-1:0]       r_beat_cnt;
  logic [LCW-1:0]       r_line_cnt;
  logic [LCW-1:0]       w_line_sel;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [ADDR_BITS-1:0] w_line_addr;
  logic [PXW-1:0]       r_wr_addr;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic                 r_done_bank;
  logic                 r_done_valid;
  logic                 r_frame_pend;
  logic                 r_underrun;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_last_burst;

  vid_edge_det u_preload_edge (
    .i_clk  (p_clk_x1),
    .i_rst  (reset),
    .i_d    (preload_vid_line),
    .o_rise (w_start)
  );

  vid_edge_det u_active_edge (
    .i_clk  (p_clk_x1),
    .i_rst  (reset),
    .i_d    (active),
    .o_rise (w_act_rise)
  );

  assign w_beat       = (r_state == ST_DATA) && mem_rd_valid;
  assign w_last_beat  = (r_beat_cnt == BTW'(BURST_LEN - 1));
  assign w_last_burst = (r_burst_cnt == BCW'(NBURST - 1));
  // A pending or coincident frame restart forces the fetch to line 0.
  assign w_line_sel   = (r_frame_pend || frame_start) ? '0 : r_line_cnt;
  assign w_line_addr  = ADDR_BITS'(FRAME_BASE) +
                        ADDR_BITS'(w_line_sel) * ADDR_BITS'(LINE_STRIDE);

  always_ff @(posedge p_clk_x1 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_REQ;
      ST_REQ:  if (mem_ack) w_state_nxt = ST_DATA;
      ST_DATA: if (w_beat && w_last_beat)
                 w_state_nxt = w_last_burst ? ST_DONE : ST_REQ;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_clk_x1 or posedge reset) begin
    if (reset) begin
      r_burst_cnt  <= '0;
      r_beat_cnt   <= '0;
      r_line_cnt   <= '0;
      r_mem_addr   <= '0;
      r_wr_addr    <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b1;
      r_done_bank  <= 1'b0;
      r_done_valid <= 1'b0;
      r_frame_pend <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_frame_pend || frame_start) begin
            r_line_cnt   <= '0;
            r_frame_pend <= 1'b0;
          end
          if (w_start) begin
            r_mem_addr  <= w_line_addr;
            r_burst_cnt <= '0;
            r_wr_addr   <= '0;
          end
        end
        ST_REQ: if (mem_ack) r_beat_cnt <= '0;
        ST_DATA: if (w_beat) begin
          r_wr_addr  <= r_wr_addr + 1'b1;
          r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_last_beat && !w_last_burst) begin
            r_mem_addr  <= r_mem_addr + ADDR_BITS'(BURST_LEN);
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done_bank <= r_wr_bank;
          r_wr_bank   <= ~r_wr_bank;
          r_line_cnt  <= (r_line_cnt == LCW'(V_RES_PIX - 1)) ? '0 : r_line_cnt + 1'b1;
        end
        default: ;
      endcase

      // Busy: defer frame restarts and drop overlapping preload edges.
      if (r_state != ST_IDLE) begin
        if (frame_start) r_frame_pend <= 1'b1;
        if (w_start)     r_underrun   <= 1'b1;
      end

      if (w_act_rise) begin
        if (r_state == ST_DONE) begin
          r_rd_bank    <= r_wr_bank;
          r_done_valid <= 1'b0;
        end else if (r_done_valid) begin
          r_rd_bank    <= r_done_bank;
          r_done_valid <= 1'b0;
        end else begin
          r_underrun   <= 1'b1;
        end
      end else if (r_state == ST_DONE) begin
        r_done_valid <= 1'b1;
      end
    end
  end

  assign mem_req     = (r_state == ST_REQ);
  assign mem_addr    = r_mem_addr;
  assign mem_len     = LENW'(BURST_LEN);
  assign buf_wr_en   = w_beat;
  assign buf_wr_bank = r_wr_bank;
  assign buf_wr_addr = r_wr_addr;
  assign rd_bank     = r_rd_bank;
  assign line_ready  = (r_state == ST_DONE);
  assign underrun    = r_underrun;
  assign busy        = (r_state != ST_IDLE);

endmodule
